corescore_collector_uart: RTL
=============================

Name: corescore_collector_uart

Overview:
- UART receiver: the receiving end of the 8N1 serial link our emitter drives.
- Oversamples the asynchronous RX line with the system clock and recovers bytes (start bit, 8 data bits LSB-first, one stop bit).
- Presents each recovered byte on a valid/ready output port.
- Used on boards where the SoC must accept host commands or loop back the emitter stream for self-test.

Parameters:
- clk_freq_hz, 16000000, system clock frequency in Hz.
- baud_rate, 1000000, line bit rate; BIT = clk_freq_hz/baud_rate (integer division), HALF = BIT/2; BIT >= 4 is required, elaboration-time error otherwise.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous reset, active-low.
- i_uart_rx  input  1  serial line, idle high, asynchronous to i_clk.
- o_data  output  8  received byte, stable while o_valid=1.
- o_valid  output  1  o_data holds an unconsumed byte.
- i_ready  input  1  consumer accepts the byte when o_valid & i_ready on a rising edge.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: byte completed while the previous byte was still unconsumed.

Behaviour:
- Reset values:
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0.
  - Synchronizer flops=1, state=IDLE, counters=0.
  - Reset mid-frame abandons the frame immediately; no pulse.
- Synchronizer: 2-flop synchronizer on i_uart_rx, reset to 1. All logic uses the synchronized value rx_s.
- Baud counter: width $clog2(BIT)+1; reloaded on every state transition; counts down; a "tick" fires at terminal count.
- State machine:
  - IDLE: wait for rx_s=0, then go to START with the counter loaded HALF-1.
  - START: at tick, sample rx_s. If 1, it was a glitch: return to IDLE, no output. If 0, go to DATA with the counter loaded BIT-1 and bit index 0.
  - DATA: at each tick, shift the sample into the shift register at the MSB (LSB-first line order) and reload BIT-1. After index 7, go to STOP with BIT-1.
  - STOP, sample 1 at tick: byte is good. Go to IDLE (early return allows up to ~5% baud mismatch).
  - STOP, sample 0 at tick: pulse o_frame_err, discard the byte, go to BREAK_WAIT.
  - BREAK_WAIT: stay until rx_s=1, then go to IDLE. A held-low line (break) yields exactly one o_frame_err.
- Output register:
  - A good byte loads o_data and sets o_valid on the cycle after the stop-bit tick.
  - o_valid clears on the o_valid & i_ready handshake.
  - If a good byte completes while o_valid=1 and i_ready=0: keep the old o_data/o_valid, drop the new byte, pulse o_overrun.
  - If a good byte completes in the same cycle as a handshake: the handshake consumes the old byte, the new byte loads, o_valid stays 1, no overrun.
- Latency: start-bit falling edge at the pin -> o_valid is 2 (sync) + HALF + 9*BIT + 1 cycles, ±1 cycle of edge-detect jitter.
- i_ready may be held high permanently; o_valid is then a pulse of at least one cycle per byte.

Optional Feature:
- Macro: CORESCORE_COLLECTOR_UART_MAJORITY_EN.
- Defined:
  - Each bit value (start, data, stop) is the 2-of-3 majority of rx_s sampled at tick-1, tick and tick+1.
  - The decision is effective at tick+1; all counter reloads shift one cycle later consistently; latency +1 cycle.
  - Requires BIT >= 6.
- Undefined: single sample at tick, as described above.

Test Plan:
- Setup: clk_freq_hz=16000000, baud_rate=1000000 (BIT=16), i_ready=1.
- 0x55 -> o_valid pulse with o_data=0x55, 2+8+144+1=155 ±1 cycles after the start edge; o_frame_err=0.
- Back-to-back 0x00, 0xFF, 0xA5 with no idle gap -> three o_valid pulses, data 0x00/0xFF/0xA5 in order, no errors.
- rx low for 3 cycles, then high -> no o_valid, no o_frame_err; state returns to IDLE; a following 0x3C is received correctly.
- 0xA3 with stop bit 0, rx then held low for 40 bit times -> exactly one o_frame_err pulse, no o_valid. After rx goes high, 0x81 is received correctly.
- i_ready=0, send 0x12 then 0x34 -> o_data=0x12, o_valid held, one o_overrun pulse at the end of 0x34. Then i_ready=1 consumes 0x12 and o_valid drops.
- Assert i_rst_n low mid-way through 0x7E -> outputs at reset values; no pulse after release. A following 0x42 is received correctly.
- Repeat all cases with CORESCORE_COLLECTOR_UART_MAJORITY_EN defined, plus 0x5A with single-cycle inverted glitches at every mid-bit -> received as 0x5A.

Source files
------------

// File: rtl/corescore_collector_uart.sv
// ============================================================================
// Module   : corescore_collector_uart
// Brief    : 8N1 UART receiver with valid/ready byte output. Optional 2-of-3
//            majority bit sampling via CORESCORE_COLLECTOR_UART_MAJORITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module corescore_collector_uart #(
   parameter int CLK_FREQ_HZ = 16000000,
   parameter int BAUD_RATE   = 1000000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_uart_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun
);

   localparam int c_BIT  = CLK_FREQ_HZ / BAUD_RATE;
   localparam int c_HALF = c_BIT / 2;
   localparam int c_CW   = $clog2(c_BIT) + 1;

   localparam logic [c_CW-1:0] c_LOAD_START = c_CW'(c_HALF - 1);
`ifdef CORESCORE_COLLECTOR_UART_MAJORITY_EN
   // Decisions land one cycle after the tick, so reload one less to keep bit pitch.
   localparam logic [c_CW-1:0] c_LOAD_BIT   = c_CW'(c_BIT - 2);
`else
   localparam logic [c_CW-1:0] c_LOAD_BIT   = c_CW'(c_BIT - 1);
`endif

   if (c_BIT < 4) begin : g_bit_check
      $error("corescore_collector_uart: CLK_FREQ_HZ/BAUD_RATE must be >= 4");
   end

`ifdef CORESCORE_COLLECTOR_UART_MAJORITY_EN
   if (c_BIT < 6) begin : g_maj_check
      $error("corescore_collector_uart: majority sampling needs CLK_FREQ_HZ/BAUD_RATE >= 6");
   end
`endif

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_START      = 3'd1,
      S_DATA       = 3'd2,
      S_STOP       = 3'd3,
      S_BREAK_WAIT = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_CW-1:0]   r_cnt;
   logic [c_CW-1:0]   w_cnt_nxt;
   logic [2:0]        r_idx;
   logic [2:0]        w_idx_nxt;
   logic [7:0]        r_shift;
   logic [7:0]        w_shift_nxt;
   logic              r_rx_meta;
   logic              r_rx_s;
   logic              w_decide;
   logic              w_sample;
   logic              w_good;
   logic              w_ferr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= i_uart_rx;
         r_rx_s    <= r_rx_meta;
      end
   end

`ifdef CORESCORE_COLLECTOR_UART_MAJORITY_EN
   logic r_rx_d1;
   logic r_rx_d2;
   logic r_pend;

   // r_pend marks the cycle after a tick, when all three samples are available.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_d1 <= 1'b1;
         r_rx_d2 <= 1'b1;
         r_pend  <= 1'b0;
      end else begin
         r_rx_d1 <= r_rx_s;
         r_rx_d2 <= r_rx_d1;
         r_pend  <= (r_cnt == '0) && !r_pend &&
                    ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP));
      end
   end

   assign w_decide = r_pend;
   assign w_sample = (r_rx_s & r_rx_d1) | (r_rx_s & r_rx_d2) | (r_rx_d1 & r_rx_d2);
`else
   assign w_decide = (r_cnt == '0);
   assign w_sample = r_rx_s;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = (r_cnt != '0) ? (r_cnt - c_CW'(1)) : r_cnt;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_good      = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_rx_s) begin
               w_state_nxt = S_START;
               w_cnt_nxt   = c_LOAD_START;
            end
         end
         S_START: begin
            if (w_decide) begin
               if (w_sample) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = S_DATA;
                  w_cnt_nxt   = c_LOAD_BIT;
                  w_idx_nxt   = '0;
               end
            end
         end
         S_DATA: begin
            if (w_decide) begin
               w_shift_nxt = {w_sample, r_shift[7:1]};
               w_cnt_nxt   = c_LOAD_BIT;
               if (r_idx == 3'd7) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
         S_STOP: begin
            // Leaving at mid-stop gives the next start edge maximum slack.
            if (w_decide) begin
               w_cnt_nxt = '0;
               if (w_sample) begin
                  w_good      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_BREAK_WAIT;
               end
            end
         end
         S_BREAK_WAIT: begin
            if (r_rx_s) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= w_ferr;
         o_overrun   <= 1'b0;
         if (w_good) begin
            if (o_valid && !i_ready) begin
               o_overrun <= 1'b1;
            end else begin
               o_data  <= r_shift;
               o_valid <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire
